alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_pkg.sv | 25 ++
 rtl/alu_op_sequencer_alu_logic_unit.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcode/state types and default widths for the ALU op sequencer
package alu_op_sequencer_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_RSVD = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_alu_logic_unit.sv
// rtl/alu_op_sequencer_alu_logic_unit.sv - single-cycle combinational logic/add/sub unit
module alu_logic_unit
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;

    // SUB is a + ~b + 1, so the top bit doubles as the no-borrow flag.
    always_comb begin
        sum      = '0;
        result_o = '0;
        carry_o  = 1'b0;
        unique case (op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_SUB: begin
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time ALU request sequencer with bit-serial shifter
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_err
);

    seq_state_t         state_q, state_d;
    alu_op_t            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic [WIDTH-1:0]   shift_next;
    logic [SHAMT_W-1:0] shamt;

    alu_logic_unit #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    assign shamt      = b_q[SHAMT_W-1:0];
    assign shift_next = (op_q == OP_SLL) ? {shreg_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = alu_op_t'(req_op);
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                unique case (op_q)
                    OP_SLL, OP_SRL: begin
                        shreg_d = a_q;
                        cnt_d   = shamt;
                        if (shamt == '0) begin
                            result_d = a_q;
                            zero_d   = (a_q == '0);
                            carry_d  = 1'b0;
                            err_d    = 1'b0;
                            state_d  = ST_RESP;
                        end else begin
                            state_d  = ST_SHIFT;
                        end
                    end
                    OP_RSVD: begin
                        result_d = '0;
                        zero_d   = 1'b1;
                        carry_d  = 1'b0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end
                    default: begin
                        result_d = alu_result;
                        zero_d   = (alu_result == '0);
                        carry_d  = alu_carry;
                        err_d    = 1'b0;
                        state_d  = ST_RESP;
                    end
                endcase
            end
            ST_SHIFT: begin
                shreg_d = shift_next;
                cnt_d   = cnt_q - SHAMT_W'(1);
                // Last shift step: publish the shifted value directly so RESP follows immediately.
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shift_next;
                    zero_d   = (shift_next == '0);
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_carry  = carry_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_err;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        e;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: results straight from the opcode definitions.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic c,
                         output logic e, output int lat);
        logic [32:0] s;
        int amt;
        amt = int'(b % 32);
        r = 0; c = 0; e = 0; lat = 2;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: begin s = 33'(a) + 33'(b); r = s[31:0]; c = s[32]; end
            3'd4: begin r = a - b; c = (a >= b); end
            3'd5: begin r = a << amt; lat = 2 + amt; end
            3'd6: begin r = a >> amt; lat = 2 + amt; end
            default: e = 1;
        endcase
        z = (r == 0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] xr, input logic xz,
                          input logic xc, input logic xe, input int xlat, input int hold);
        int  lat;
        bit  seen;
        bit  stable;
        logic [31:0] first;
        @(negedge clk);
        chk({name, " req_ready idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 1; seen = 0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) seen = 1;
        end
        chk({name, " rsp_valid seen"}, 64'(seen), 64'd1);
        chk({name, " latency"}, 64'(lat), 64'(xlat));
        chk({name, " result"}, 64'(rsp_result), 64'(xr));
        chk({name, " flags zce"}, 64'({rsp_zero, rsp_carry, rsp_err}), 64'({xz, xc, xe}));
        first = rsp_result;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || req_ready || rsp_result !== first) stable = 0;
        end
        if (hold > 0) chk({name, " backpressure stable"}, 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, " single response"}, 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    task automatic run_model(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int hold);
        logic [31:0] r; logic z, c, e; int lat;
        model(op, a, b, r, z, c, e, lat);
        run_op(name, op, a, b, r, z, c, e, lat, hold);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

        vecs[0]  = '{3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 2, 0};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 1, 0, 2, 0};
        vecs[2]  = '{3'd4, 32'h3,         32'h5,         32'hFFFF_FFFE, 0, 0, 0, 2, 0};
        vecs[3]  = '{3'd4, 32'h5,         32'h3,         32'h2,         0, 1, 0, 2, 0};
        vecs[4]  = '{3'd4, 32'h7,         32'h7,         32'h0,         1, 1, 0, 2, 0};
        vecs[5]  = '{3'd5, 32'h1,         32'd31,        32'h8000_0000, 0, 0, 0, 33, 0};
        vecs[6]  = '{3'd6, 32'h8000_0000, 32'd0,         32'h8000_0000, 0, 0, 0, 2, 0};
        vecs[7]  = '{3'd6, 32'h8000_0000, 32'h24,        32'h0800_0000, 0, 0, 0, 6, 0};
        vecs[8]  = '{3'd7, 32'h1234,      32'h5,         32'h0,         1, 0, 1, 2, 0};
        vecs[9]  = '{3'd3, 32'h2,         32'h3,         32'h5,         0, 0, 0, 2, 0};
        vecs[10] = '{3'd1, 32'h0,         32'h0,         32'h0,         1, 0, 0, 2, 0};
        vecs[11] = '{3'd2, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 0, 0, 0, 2, 0};
        vecs[12] = '{3'd1, 32'h00FF_0000, 32'h0000_00FF, 32'h00FF_00FF, 0, 0, 0, 2, 10};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 64'({rsp_valid, rsp_zero, rsp_carry, rsp_err}), 64'd0);
        chk("reset result", 64'(rsp_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready after reset", 64'(req_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].z, vecs[i].c, vecs[i].e, vecs[i].lat, vecs[i].hold);
        end

        // Reset while SRL by 20 is mid-shift.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd6; req_a = 32'hDEAD_BEEF; req_b = 32'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready after mid-shift reset", 64'(req_ready), 64'd1);
        repeat (25) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk("no response after abort", 64'(seen), 64'd0);
        run_model("post-reset add", 3'd3, 32'd2, 32'd2, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = 0;
            if (i % 7 == 0) b = a;
            run_model($sformatf("rand%0d op%0d", i, op), op, a, b, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
